bs_split: RTL and testbench

//  Bitstream splitter: the read side of the bitstream packer. Accepts packed 32-bit words
//  (oldest bit at MSB, as produced by the packer) and returns fields of 1..32 bits on request,

---
 rtl/bs_split_if.sv | 33 +++
 rtl/bs_split.sv | 83 ++++++++
 tb/tb_bs_split.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bs_split_if.sv
// Handshake bundle between the bitstream splitter and its producer/consumer.
// Optional align_i appears only when BS_SPLIT_BYTE_ALIGN_EN is defined.
interface bs_split_if;
   logic        clr_i;
   logic        val_i;
   logic [31:0] dat_i;
   logic        rdy_o;
   logic        req_i;
   logic [4:0]  numb_i;
   logic        req_rdy_o;
   logic        val_o;
   logic [31:0] dat_o;
   logic [6:0]  cnt_o;
`ifdef BS_SPLIT_BYTE_ALIGN_EN
   logic        align_i;
`endif

   modport master (
      output clr_i, val_i, dat_i, req_i, numb_i,
`ifdef BS_SPLIT_BYTE_ALIGN_EN
      output align_i,
`endif
      input  rdy_o, req_rdy_o, val_o, dat_o, cnt_o
   );

   modport slave (
      input  clr_i, val_i, dat_i, req_i, numb_i,
`ifdef BS_SPLIT_BYTE_ALIGN_EN
      input  align_i,
`endif
      output rdy_o, req_rdy_o, val_o, dat_o, cnt_o
   );
endinterface

// File: rtl/bs_split.sv
// Bitstream splitter: unpacks MSB-first 32-bit words into right-aligned 1..32 bit fields.
// Optional head byte-alignment is compiled in with BS_SPLIT_BYTE_ALIGN_EN.
module bs_split (
   input  logic       clk,
   input  logic       rstn,
   bs_split_if.slave  bus
);
   logic [63:0] buf_r;
   logic [63:0] buf_cons;
   logic [63:0] buf_algn;
   logic [63:0] buf_nxt;
   logic [6:0]  cnt_r;
   logic [6:0]  cnt_cons;
   logic [6:0]  cnt_algn;
   logic [6:0]  cnt_nxt;
   logic [6:0]  len;
   logic [31:0] field;
   logic [31:0] dat_r;
   logic        val_r;
   logic        take;
   logic        load;

   // Field length is widened before the +1 so numb_i=31 yields 32, not 0.
   assign len           = 7'(bus.numb_i) + 7'd1;
   assign bus.rdy_o     = (cnt_r <= 7'd32);
   assign bus.req_rdy_o = (cnt_r >= len);
   assign bus.val_o     = val_r;
   assign bus.dat_o     = dat_r;
   assign bus.cnt_o     = cnt_r;

   assign take  = bus.req_i & bus.req_rdy_o;
   assign load  = bus.val_i & bus.rdy_o;
   assign field = buf_r[63:32] >> (6'd32 - len[5:0]);

   // Consume, then optional align, then append at the reduced count: same as doing them in sequence.
   always_comb begin
      buf_cons = buf_r;
      cnt_cons = cnt_r;
      if (take) begin
         buf_cons = buf_r << len;
         cnt_cons = cnt_r - len;
      end

      buf_algn = buf_cons;
      cnt_algn = cnt_cons;
`ifdef BS_SPLIT_BYTE_ALIGN_EN
      if (bus.align_i) begin
         buf_algn = buf_cons << cnt_cons[2:0];
         cnt_algn = cnt_cons - 7'(cnt_cons[2:0]);
      end
`endif

      buf_nxt = buf_algn;
      cnt_nxt = cnt_algn;
      if (load) begin
         buf_nxt = buf_algn | ({bus.dat_i, 32'h0} >> cnt_algn);
         cnt_nxt = cnt_algn + 7'd32;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         buf_r <= '0;
         cnt_r <= '0;
         val_r <= 1'b0;
         dat_r <= '0;
      end else if (bus.clr_i) begin
         buf_r <= '0;
         cnt_r <= '0;
         val_r <= 1'b0;
      end else begin
         buf_r <= buf_nxt;
         cnt_r <= cnt_nxt;
         val_r <= take;
         if (take) dat_r <= field;
      end
   end

   // Invariants: count never exceeds capacity and bits past the fill level stay clear.
   a_cnt_range: assert property (@(posedge clk) disable iff (!rstn) cnt_r <= 7'd64);
   a_tail_zero: assert property (@(posedge clk) disable iff (!rstn)
                                 (buf_r & (~64'h0 >> cnt_r)) == 64'h0);
endmodule

// File: tb/tb_bs_split.sv
// Bench for bs_split: directed cases plus random traffic checked against a bit-queue model.
module tb_bs_split;
`ifdef BS_SPLIT_BYTE_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   bs_split_if bus ();

   bs_split dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit q[$];
   logic [31:0] last_dat = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic r,
                        input logic [4:0] nb, input logic c, input logic a);
      bus.val_i  = v;
      bus.dat_i  = d;
      bus.req_i  = r;
      bus.numb_i = nb;
      bus.clr_i  = c;
`ifdef BS_SPLIT_BYTE_ALIGN_EN
      bus.align_i = a;
`endif
   endtask

   // One clock of traffic: check handshake outputs mid-cycle, update the model, check the registered result.
   task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                      input logic [4:0] nb, input logic c, input logic a);
      int n;
      bit acc_w, acc_r, exp_val;
      logic [31:0] f;
      drive(v, d, r, nb, c, a);
      n = int'(nb) + 1;
      @(negedge clk);
      check("cnt", 64'(bus.cnt_o), 64'(q.size()));
      check("rdy", 64'(bus.rdy_o), 64'(q.size() <= 32));
      check("req_rdy", 64'(bus.req_rdy_o), 64'(q.size() >= n));
      acc_w = v && (q.size() <= 32);
      acc_r = r && (q.size() >= n);
      exp_val = 1'b0;
      if (c) begin
         q.delete();
      end else begin
         if (acc_r) begin
            f = '0;
            for (int i = 0; i < n; i++) f = {f[30:0], q.pop_front()};
            last_dat = f;
            exp_val = 1'b1;
         end
         if (a && ALIGN) begin
            int k = q.size() % 8;
            for (int i = 0; i < k; i++) void'(q.pop_front());
         end
         if (acc_w) for (int i = 31; i >= 0; i--) q.push_back(d[i]);
      end
      @(posedge clk);
      #1;
      check("val", 64'(bus.val_o), 64'(exp_val));
      check("dat", 64'(bus.dat_o), 64'(last_dat));
   endtask

   task automatic async_reset();
      drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check("ar_cnt", 64'(bus.cnt_o), 64'd0);
      check("ar_val", 64'(bus.val_o), 64'd0);
      check("ar_dat", 64'(bus.dat_o), 64'd0);
      check("ar_rdy", 64'(bus.rdy_o), 64'd1);
      q.delete();
      last_dat = '0;
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_cnt", 64'(bus.cnt_o), 64'd0);
      check("rst_rdy", 64'(bus.rdy_o), 64'd1);
      check("rst_req_rdy", 64'(bus.req_rdy_o), 64'd0);
      check("rst_val", 64'(bus.val_o), 64'd0);
      check("rst_dat", 64'(bus.dat_o), 64'd0);
      rstn = 1'b1;

      // Single word split into 4/4/8/16 bit fields
      cyc(1, 32'hDEADBEEF, 0, 5'd0, 0, 0);
      cyc(0, '0, 1, 5'd3, 0, 0);  check("t1_a", 64'(bus.dat_o), 64'hD);
      cyc(0, '0, 1, 5'd3, 0, 0);  check("t1_b", 64'(bus.dat_o), 64'hE);
      cyc(0, '0, 1, 5'd7, 0, 0);  check("t1_c", 64'(bus.dat_o), 64'hAD);
      cyc(0, '0, 1, 5'd15, 0, 0); check("t1_d", 64'(bus.dat_o), 64'hBEEF);

      // Field crossing the word boundary
      cyc(1, 32'h12345678, 0, 5'd0, 0, 0);
      cyc(1, 32'h9ABCDEF0, 0, 5'd0, 0, 0);
      cyc(0, '0, 1, 5'd11, 0, 0); check("t2_a", 64'(bus.dat_o), 64'h123);
      cyc(0, '0, 1, 5'd31, 0, 0); check("t2_b", 64'(bus.dat_o), 64'h456789AB);
      cyc(0, '0, 0, 5'd0, 1, 0);

      // Full buffer back-pressure
      cyc(1, 32'h11111111, 0, 5'd0, 0, 0);
      cyc(1, 32'h22222222, 0, 5'd0, 0, 0);
      check("t3_cnt", 64'(bus.cnt_o), 64'd64);
      check("t3_rdy", 64'(bus.rdy_o), 64'd0);
      cyc(1, 32'h33333333, 0, 5'd0, 0, 0);
      cyc(1, 32'h33333333, 1, 5'd31, 0, 0);
      check("t3_dat", 64'(bus.dat_o), 64'h11111111);
      check("t3_rdy2", 64'(bus.rdy_o), 64'd1);
      cyc(0, '0, 0, 5'd0, 1, 0);

      // Request stalls on 8 bits while the word lands, then spans both
      cyc(1, 32'hCAFEF00D, 0, 5'd0, 0, 0);
      cyc(0, '0, 1, 5'd23, 0, 0); check("t4_a", 64'(bus.dat_o), 64'hCAFEF0);
      cyc(1, 32'h12345678, 1, 5'd15, 0, 0);
      check("t4_stall", 64'(bus.val_o), 64'd0);
      cyc(0, '0, 1, 5'd15, 0, 0); check("t4_b", 64'(bus.dat_o), 64'h0D12);

      // Flush wins over simultaneous request and append
      cyc(1, 32'hFFFFFFFF, 1, 5'd3, 1, 0);
      check("t5_cnt", 64'(bus.cnt_o), 64'd0);
      cyc(1, 32'h80000001, 0, 5'd0, 0, 0);
      cyc(0, '0, 1, 5'd0, 0, 0);  check("t5_a", 64'(bus.dat_o), 64'h1);
      cyc(0, '0, 1, 5'd30, 0, 0); check("t5_b", 64'(bus.dat_o), 64'h1);

`ifdef BS_SPLIT_BYTE_ALIGN_EN
      cyc(0, '0, 0, 5'd0, 1, 0);
      cyc(1, 32'hA5A5A5A5, 0, 5'd0, 0, 0);
      cyc(0, '0, 1, 5'd2, 0, 0);  check("t6_a", 64'(bus.dat_o), 64'h5);
      cyc(0, '0, 0, 5'd0, 0, 1);  check("t6_cnt", 64'(bus.cnt_o), 64'd24);
      cyc(0, '0, 1, 5'd7, 0, 0);  check("t6_b", 64'(bus.dat_o), 64'hA5);
`endif

      for (int i = 0; i < 3000; i++) begin
         logic [4:0] nb;
         nb = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         if (i == 1500) async_reset();
         cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, nb,
             $urandom_range(0, 99) == 0, ALIGN && ($urandom_range(0, 15) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
